// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between a fetch controller and pc_unit.
//
// Parameter:
//   XLEN  address width in bits
//
// Signals:
//   stall, br_taken, br_offset, jmp, jmp_target, call, ret, trap
//       next-PC requests, driven by the master
//   pc_out, pc_next, ras_empty, ras_full, ras_err, misalign
//       PC unit status, driven by the slave (pc_unit)
//
// Modports:
//   master  fetch controller side
//   slave   pc_unit side
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_offset;
  logic            jmp;
  logic [XLEN-1:0] jmp_target;
  logic            call;
  logic            ret;
  logic            trap;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;
  logic            misalign;

  modport master (
    output stall, br_taken, br_offset, jmp, jmp_target, call, ret, trap,
    input  pc_out, pc_next, ras_empty, ras_full, ras_err, misalign
  );

  modport slave (
    input  stall, br_taken, br_offset, jmp, jmp_target, call, ret, trap,
    output pc_out, pc_next, ras_empty, ras_full, ras_err, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with relative branch, absolute jump, trap redirect
// and a circular return-address stack (RAS) for nested call/return.
//
// Parameters:
//   XLEN       address width
//   STEP       byte increment per sequential instruction (power of two)
//   RESET_VEC  pc_out after reset
//   TRAP_VEC   trap redirect address
//   RAS_DEPTH  return-address stack entries (power of two, >= 2)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_unit_if.slave: requests in; pc_out, pc_next, ras_empty,
//        ras_full, ras_err, misalign out
//
// Next-PC priority: trap > stall > ret > jmp (optionally call) > br_taken
// > increment. All arithmetic wraps modulo 2^XLEN.
//
// Build option: define PC_ALIGN_CHECK_EN to redirect jump/branch/ret targets
// whose low log2(STEP) bits are nonzero to TRAP_VEC and pulse misalign.
// Without it targets load unchanged and misalign is tied low.
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter int              STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);
  localparam logic [CW-1:0]   FULL_V = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_d;
  logic            load_tgt;
  logic            push;
  logic            pop;
  logic            err_set;
  logic            ras_empty_w;
  logic            ras_full_w;

  assign pc_inc      = pc_q + STEP_V;
  // Pointer addresses the next free slot, so the top of stack is one below.
  assign ras_top     = ras_mem[ptr_q - PW'(1)];
  assign ras_empty_w = (cnt_q == '0);
  assign ras_full_w  = (cnt_q == FULL_V);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  logic mis_d;
  logic mis_q;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pc_d     = pc_inc;
    tgt      = pc_inc;
    load_tgt = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d    = 1'b0;
`endif
    if (bus.trap) begin
      pc_d = TRAP_VEC;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      // ret outranks a simultaneous call, so no push happens in that cycle.
      if (!ras_empty_w) begin
        tgt      = ras_top;
        load_tgt = 1'b1;
        pop      = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (bus.jmp) begin
      tgt      = bus.jmp_target;
      load_tgt = 1'b1;
      push     = bus.call;
      err_set  = bus.call && ras_full_w;
    end else if (bus.br_taken) begin
      tgt      = pc_q + bus.br_offset;
      load_tgt = 1'b1;
    end

    if (load_tgt) begin
      pc_d = tgt;
`ifdef PC_ALIGN_CHECK_EN
      // A redirected ret has already popped above; only the load changes.
      if ((tgt & ALIGN_MASK) != '0) begin
        pc_d  = TRAP_VEC;
        mis_d = 1'b1;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (push) begin
        ptr_q <= ptr_q + PW'(1);
        // Pushing while full overwrites the oldest entry; count stays put.
        if (!ras_full_w) cnt_q <= cnt_q + CW'(1);
      end else if (pop) begin
        ptr_q <= ptr_q - PW'(1);
        cnt_q <= cnt_q - CW'(1);
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // NOTE: the stack storage has no reset; count and pointer define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ptr_q] <= pc_inc;
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign bus.misalign = mis_q;
`else
  assign bus.misalign = 1'b0;
`endif

  assign bus.pc_out    = pc_q;
  assign bus.pc_next   = pc_d;
  assign bus.ras_empty = ras_empty_w;
  assign bus.ras_full  = ras_full_w;
  assign bus.ras_err   = err_q;

endmodule
